// File: rtl/cpu_pkg.sv
// Shared widths and fetch-FSM state encodings for the CPU front end.
package cpu_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// Small in-order FIFO holding fetched {pc, instr} pairs for the decode stage.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Pointers are power-of-two sized so they wrap without explicit compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: one memory read per PC value, results queued for decode.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_addr,
    output logic               pc_pause,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               flush,
    input  logic               id_stall,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc
);

    localparam int ENTRY_W = ADDR_W + INSTR_W;

    fetch_state_e        r_state;
    fetch_state_e        w_next_state;
    logic [ADDR_W-1:0]   r_saved_addr;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [ENTRY_W-1:0]  w_head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_saved_addr <= '0;
        end else begin
            r_state <= w_next_state;
            // A flushed fetch still owns the bus; remember its address until it acks.
            if (r_state == S_FETCH && w_next_state == S_DRAIN) begin
                r_saved_addr <= pc_addr;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        imem_req     = 1'b0;
        imem_addr    = '0;
        w_push       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                imem_req  = !w_full;
                imem_addr = pc_addr;
                w_push    = imem_req && imem_ack && !flush;
                if (flush && imem_req && !imem_ack) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = r_saved_addr;
                if (imem_ack) begin
                    w_next_state = S_FETCH;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        pc_pause = !(((r_state == S_FETCH) && imem_req && imem_ack) || flush);
    end

    assign w_pop = if_valid && !id_stall && !flush;

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .clear (flush),
        .din   ({pc_addr, imem_rdata}),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    // Head fields read as zero when nothing is queued.
    assign if_valid = !w_empty;
    assign if_pc    = w_empty ? '0 : w_head[ENTRY_W-1:INSTR_W];
    assign if_instr = w_empty ? '0 : w_head[INSTR_W-1:0];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit with a behavioural PC register and memory.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pcReg;
    logic        pc_pause;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        flush;
    logic        id_stall;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] flushTarget;
    logic        ackDrive;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] memWord(input logic [15:0] a);
        logic [15:0] p;
        p = 16'(a * 16'h03B1);
        return p ^ 16'hC0DE;
    endfunction

    assign imem_ack   = ackDrive && imem_req;
    assign imem_rdata = imem_ack ? memWord(imem_addr) : 16'h0000;

    // PC register: holds while paused, otherwise steps by 2 or takes the redirect.
    always @(posedge clk or posedge rst) begin
        if (rst)
            pcReg <= 16'h0000;
        else if (!pc_pause)
            pcReg <= flush ? flushTarget : 16'(pcReg + 16'd2);
    end

    if_fetch_unit #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_addr    (pcReg),
        .pc_pause   (pc_pause),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .flush      (flush),
        .id_stall   (id_stall),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc)
    );

    task automatic applyStimulus(input logic ack, input logic stall, input logic fl,
                                 input logic [15:0] tgt);
        @(negedge clk);
        ackDrive    = ack;
        id_stall    = stall;
        flush       = fl;
        flushTarget = tgt;
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({imem_req, pc_pause, if_valid, imem_addr, if_pc, if_instr} !== {3'b010, 48'h0}) begin
            errors++;
            $display("[TB] FAIL reset_hold: got req=%b pause=%b valid=%b addr=%h pc=%h instr=%h expected 0/1/0/0/0/0",
                     imem_req, pc_pause, if_valid, imem_addr, if_pc, if_instr);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({imem_req, pc_pause, if_valid} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL reset_idle: got req=%b pause=%b valid=%b expected 0/1/0", imem_req, pc_pause, if_valid);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
        checks++;
        if ({imem_req, pc_pause, imem_addr} !== {2'b11, 16'h0000}) begin
            errors++;
            $display("[TB] FAIL reset_first_req: got req=%b pause=%b addr=%h expected 1/1/0000", imem_req, pc_pause, imem_addr);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        checks++;
        if ({imem_req, pc_pause} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL reset_first_ack: got req=%b pause=%b expected 1/0", imem_req, pc_pause);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
        checks++;
        if ({if_valid, if_pc, if_instr, imem_req, imem_addr} !== {1'b1, 16'h0000, memWord(16'h0000), 1'b1, 16'h0002}) begin
            errors++;
            $display("[TB] FAIL reset_prefill: got valid=%b pc=%h instr=%h req=%b addr=%h expected 1/0000/%h/1/0002",
                     if_valid, if_pc, if_instr, imem_req, imem_addr, memWord(16'h0000));
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({imem_req, pc_pause, if_valid, imem_addr, if_pc, if_instr} !== {3'b010, 48'h0}) begin
            errors++;
            $display("[TB] FAIL reset_midwait: got req=%b pause=%b valid=%b addr=%h pc=%h instr=%h expected 0/1/0/0/0/0",
                     imem_req, pc_pause, if_valid, imem_addr, if_pc, if_instr);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({imem_req, pc_pause, if_valid} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL reset_idle2: got req=%b pause=%b valid=%b expected 0/1/0", imem_req, pc_pause, if_valid);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("[TB] FAIL reset_restart: got req=%b addr=%h expected 1/0000", imem_req, imem_addr);
        end
    endtask

    task automatic test_zero_wait();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
            checks++;
            if ({imem_req, pc_pause, imem_addr} !== {2'b10, 16'(2 * k)}) begin
                errors++;
                $display("[TB] FAIL zero_wait_req[%0d]: got req=%b pause=%b addr=%h expected 1/0/%h",
                         k, imem_req, pc_pause, imem_addr, 16'(2 * k));
            end
            checks++;
            if (k == 0) begin
                if (if_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL zero_wait_empty: got valid=%b expected 0", if_valid);
                end
            end else if ({if_valid, if_pc, if_instr} !== {1'b1, 16'(2 * (k - 1)), memWord(16'(2 * (k - 1)))}) begin
                errors++;
                $display("[TB] FAIL zero_wait_head[%0d]: got valid=%b pc=%h instr=%h expected 1/%h/%h",
                         k, if_valid, if_pc, if_instr, 16'(2 * (k - 1)), memWord(16'(2 * (k - 1))));
            end
        end
    endtask

    task automatic test_three_wait();
        for (int w = 0; w < 3; w++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
            checks++;
            if ({imem_req, pc_pause, imem_addr} !== {2'b11, 16'h0008}) begin
                errors++;
                $display("[TB] FAIL wait3_hold[%0d]: got req=%b pause=%b addr=%h expected 1/1/0008",
                         w, imem_req, pc_pause, imem_addr);
            end
            if (w == 0) begin
                checks++;
                if ({if_valid, if_pc} !== {1'b1, 16'h0006}) begin
                    errors++;
                    $display("[TB] FAIL wait3_tail: got valid=%b pc=%h expected 1/0006", if_valid, if_pc);
                end
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        checks++;
        if ({imem_req, pc_pause, imem_addr, if_valid} !== {2'b10, 16'h0008, 1'b0}) begin
            errors++;
            $display("[TB] FAIL wait3_ack: got req=%b pause=%b addr=%h valid=%b expected 1/0/0008/0",
                     imem_req, pc_pause, imem_addr, if_valid);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
        checks++;
        if ({if_valid, if_pc, if_instr, imem_addr, pc_pause} !== {1'b1, 16'h0008, memWord(16'h0008), 16'h000A, 1'b1}) begin
            errors++;
            $display("[TB] FAIL wait3_result: got valid=%b pc=%h instr=%h addr=%h pause=%b expected 1/0008/%h/000a/1",
                     if_valid, if_pc, if_instr, imem_addr, pc_pause, memWord(16'h0008));
        end
    endtask

    task automatic test_stall();
        for (int s = 0; s < 5; s++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
            checks++;
            if (s == 0) begin
                if ({imem_req, pc_pause, imem_addr, if_valid} !== {2'b10, 16'h000A, 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL stall_fill0: got req=%b pause=%b addr=%h valid=%b expected 1/0/000a/0",
                             imem_req, pc_pause, imem_addr, if_valid);
                end
            end else if (s == 1) begin
                if ({imem_req, pc_pause, imem_addr, if_valid, if_pc} !== {2'b10, 16'h000C, 1'b1, 16'h000A}) begin
                    errors++;
                    $display("[TB] FAIL stall_fill1: got req=%b pause=%b addr=%h valid=%b pc=%h expected 1/0/000c/1/000a",
                             imem_req, pc_pause, imem_addr, if_valid, if_pc);
                end
            end else if ({imem_req, pc_pause, if_valid, if_pc} !== {3'b011, 16'h000A}) begin
                errors++;
                $display("[TB] FAIL stall_full[%0d]: got req=%b pause=%b valid=%b pc=%h expected 0/1/1/000a",
                         s, imem_req, pc_pause, if_valid, if_pc);
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        checks++;
        if ({imem_req, pc_pause, if_pc, if_instr} !== {2'b01, 16'h000A, memWord(16'h000A)}) begin
            errors++;
            $display("[TB] FAIL stall_release0: got req=%b pause=%b pc=%h instr=%h expected 0/1/000a/%h",
                     imem_req, pc_pause, if_pc, if_instr, memWord(16'h000A));
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        checks++;
        if ({imem_req, pc_pause, imem_addr, if_pc, if_instr} !== {2'b10, 16'h000E, 16'h000C, memWord(16'h000C)}) begin
            errors++;
            $display("[TB] FAIL stall_release1: got req=%b pause=%b addr=%h pc=%h instr=%h expected 1/0/000e/000c/%h",
                     imem_req, pc_pause, imem_addr, if_pc, if_instr, memWord(16'h000C));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
        checks++;
        if ({imem_req, pc_pause, imem_addr, if_valid, if_pc} !== {2'b11, 16'h0010, 1'b1, 16'h000E}) begin
            errors++;
            $display("[TB] FAIL stall_release2: got req=%b pause=%b addr=%h valid=%b pc=%h expected 1/1/0010/1/000e",
                     imem_req, pc_pause, imem_addr, if_valid, if_pc);
        end
    endtask

    task automatic test_flush_wait();
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0040);
        checks++;
        if ({imem_req, pc_pause, imem_addr, if_valid} !== {2'b10, 16'h0010, 1'b1}) begin
            errors++;
            $display("[TB] FAIL flushw_cycle: got req=%b pause=%b addr=%h valid=%b expected 1/0/0010/1",
                     imem_req, pc_pause, imem_addr, if_valid);
        end
        for (int d = 0; d < 3; d++) begin
            applyStimulus(d == 2, 1'b0, 1'b0, 16'h0);
            checks++;
            if ({imem_req, pc_pause, imem_addr, if_valid, if_pc} !== {2'b11, 16'h0010, 1'b0, 16'h0000}) begin
                errors++;
                $display("[TB] FAIL flushw_drain[%0d]: got req=%b pause=%b addr=%h valid=%b pc=%h expected 1/1/0010/0/0000",
                         d, imem_req, pc_pause, imem_addr, if_valid, if_pc);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
        checks++;
        if ({imem_req, imem_addr, if_valid} !== {1'b1, 16'h0040, 1'b0}) begin
            errors++;
            $display("[TB] FAIL flushw_redirect: got req=%b addr=%h valid=%b expected 1/0040/0", imem_req, imem_addr, if_valid);
        end
    endtask

    task automatic test_flush_ack();
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0020);
        checks++;
        if ({imem_req, pc_pause, imem_addr} !== {2'b10, 16'h0040}) begin
            errors++;
            $display("[TB] FAIL flusha_first: got req=%b pause=%b addr=%h expected 1/0/0040", imem_req, pc_pause, imem_addr);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0080);
        checks++;
        if ({imem_req, pc_pause, imem_addr, if_valid} !== {2'b10, 16'h0020, 1'b0}) begin
            errors++;
            $display("[TB] FAIL flusha_0020: got req=%b pause=%b addr=%h valid=%b expected 1/0/0020/0",
                     imem_req, pc_pause, imem_addr, if_valid);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
        checks++;
        if ({imem_req, pc_pause, imem_addr, if_valid} !== {2'b10, 16'h0080, 1'b0}) begin
            errors++;
            $display("[TB] FAIL flusha_nodrain: got req=%b pause=%b addr=%h valid=%b expected 1/0/0080/0",
                     imem_req, pc_pause, imem_addr, if_valid);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
        checks++;
        if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 16'h0080, memWord(16'h0080), 16'h0082}) begin
            errors++;
            $display("[TB] FAIL flusha_result: got valid=%b pc=%h instr=%h addr=%h expected 1/0080/%h/0082",
                     if_valid, if_pc, if_instr, imem_addr, memWord(16'h0080));
        end
    endtask

    // Reference: expected queue of fetched PCs, next address to fetch, and a pending discarded transfer.
    task automatic test_random(input int cycles);
        logic [15:0] expQ[$];
        logic [15:0] nextFetch;
        logic [15:0] drainAddr;
        logic        discardPending;
        logic        expReq;
        logic        expPause;
        logic        ackNow;
        nextFetch      = 16'h0082;
        drainAddr      = 16'h0000;
        discardPending = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 15) == 0, 16'($urandom) & 16'hFFFE);
            expReq   = discardPending ? 1'b1 : (expQ.size() < 2);
            ackNow   = expReq && ackDrive;
            expPause = !((ackNow && !discardPending) || flush);
            checks++;
            if ({imem_req, pc_pause} !== {expReq, expPause}) begin
                errors++;
                $display("[TB] FAIL rand_ctrl[%0d]: got req=%b pause=%b expected %b/%b", c, imem_req, pc_pause, expReq, expPause);
            end
            if (expReq) begin
                checks++;
                if (imem_addr !== (discardPending ? drainAddr : nextFetch)) begin
                    errors++;
                    $display("[TB] FAIL rand_addr[%0d]: got addr=%h expected %h", c, imem_addr,
                             discardPending ? drainAddr : nextFetch);
                end
            end
            checks++;
            if (expQ.size() == 0) begin
                if ({if_valid, if_pc, if_instr} !== 33'h0) begin
                    errors++;
                    $display("[TB] FAIL rand_empty[%0d]: got valid=%b pc=%h instr=%h expected 0/0/0", c, if_valid, if_pc, if_instr);
                end
            end else if ({if_valid, if_pc, if_instr} !== {1'b1, expQ[0], memWord(expQ[0])}) begin
                errors++;
                $display("[TB] FAIL rand_head[%0d]: got valid=%b pc=%h instr=%h expected 1/%h/%h",
                         c, if_valid, if_pc, if_instr, expQ[0], memWord(expQ[0]));
            end
            if (flush) begin
                expQ.delete();
                if (discardPending) begin
                    if (ackNow) discardPending = 1'b0;
                end else if (expReq && !ackNow) begin
                    discardPending = 1'b1;
                    drainAddr      = nextFetch;
                end
                nextFetch = flushTarget;
            end else begin
                if (expQ.size() > 0 && !id_stall) void'(expQ.pop_front());
                if (discardPending) begin
                    if (ackNow) discardPending = 1'b0;
                end else if (ackNow) begin
                    expQ.push_back(nextFetch);
                    nextFetch = 16'(nextFetch + 16'd2);
                end
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        ackDrive    = 1'b0;
        flush       = 1'b0;
        id_stall    = 1'b0;
        flushTarget = 16'h0000;
        test_reset();
        test_zero_wait();
        test_three_wait();
        test_stall();
        test_flush_wait();
        test_flush_ack();
        test_random(2000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
